fios_job_scheduler: RTL and testbench
=====================================

# fios_job_scheduler

Round-robin job scheduler that shares one FIOS Montgomery multiplier among several requesters. It latches a requester's operand slot, issues the multiplier start pulse, and turns the multiplier's a_shift/b_fetch/p_fetch/RES_push strobes into word addresses for shared operand and result RAMs. It acknowledges the requester on completion and flags protocol errors and timeouts. It sits between the requester fabric and the FIOS multiplier top level.

## Interface
Parameters:
- s, 8, words of 17 bits per operand; multiplier iterations per job
- NREQ, 4, number of requesters (2..16)
- SLOT_W, 4, slot index width; RAM word address = slot*s + word index
- ADDR_W, 8, RAM address width; must satisfy 2^ADDR_W >= 2^SLOT_W*s
- TIMEOUT, 4096, max cycles from start pulse to multiplier done

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- req_i  in  NREQ  per-requester job request, level, held until ack
- req_slot_i  in  NREQ*SLOT_W  slot of requester k at bits [k*SLOT_W +: SLOT_W]
- ack_o  out  NREQ  one-cycle completion pulse to the granted requester
- err_o  out  1  sticky error; cleared only by reset
- busy_o  out  1  high from grant until ack
- mult_start_o  out  1  one-cycle start pulse to the multiplier
- a_shift_i, b_fetch_i, p_fetch_i, res_push_i, done_i  in  1 each  multiplier strobes
- a_addr_o, b_addr_o, p_addr_o  out  ADDR_W each  operand RAM read addresses
- res_addr_o  out  ADDR_W  result RAM write address
- res_we_o  out  1  result RAM write enable, combinational from res_push_i

## Operation
- States: IDLE, GRANT, START, RUN, ACK.
- IDLE: if any req_i is set, pick the first set bit at or after rr_ptr (wrapping), latch its index and slot, and go to GRANT. rr_ptr then becomes index+1 mod NREQ.
- GRANT: clear all word counters, set a_addr = b_addr = p_addr = res_addr = slot*s, and go to START.
- START: drive mult_start_o=1 for exactly one cycle, clear the watchdog, and go to RUN.
- RUN, counter behaviour:
  - a_shift_i increments a_idx, saturating at s-1.
  - b_fetch_i increments b_idx mod s.
  - p_fetch_i increments p_idx mod s.
  - res_push_i drives res_we_o=1 when res_cnt<s, and res_cnt increments after that write.
  - Counters are independent; simultaneous strobes all take effect in the same cycle.
  - Every address output is slot*s plus its own index, and is registered.
- RUN, exit conditions:
  - On done_i: if res_cnt (including a push in the same cycle) is not s, set err_o. Go to ACK.
  - If the watchdog reaches TIMEOUT: set err_o and go to ACK.
- ACK: pulse ack_o[index] for one cycle, return to IDLE, and deassert busy_o.
- Boundary cases:
  - res_push_i while res_cnt==s: res_we_o=0, err_o set.
  - Strobes outside RUN are ignored and do not set err_o.
  - Deassertion of req_i by the granted requester mid-job is ignored; the job completes and acks.
  - Changes to req_slot_i after the IDLE cycle are ignored.
- Arithmetic: slot*s computed at ADDR_W bits with no truncation (guaranteed by the parameter rule); word indices are $clog2(s) bits.

## Timing
- Reset (async assert, sync deassert): state=IDLE, rr_ptr=0, all counters 0. Every output is 0: ack_o, err_o, busy_o, mult_start_o, all addresses, res_we_o.
- Reset mid-job: outputs go to 0 immediately and no ack is issued. The multiplier must be reset by the same reset_i.
- Request to mult_start_o: request seen in IDLE at cycle t → GRANT at t+1 (busy_o=1) → mult_start_o=1 at t+2.
- Addresses are valid from t+2 onward.
- A strobe at cycle c updates its address at c+1; the RAM read latency is 1 cycle and is matched by the multiplier fetch pipeline.
- res_we_o and res_addr_o are valid in the same cycle as res_push_i (address is pre-incremented).
- done_i at cycle d → ack_o at d+1 → IDLE at d+2; a new grant is possible at d+2.
- Minimum back-to-back job spacing from ack to next start: 3 cycles.

## Test plan
- Single job: req_i=0001, slot 3, s=8 → mult_start_o at cycle 2; a_addr, b_addr and p_addr start at 24. Then 8 pushes write addresses 24..31; done_i → ack_o=0001 one cycle later, err_o=0.
- Round robin: req_i=1111 held for all jobs → grants in order 0,1,2,3,0; each ack pulses exactly once per job.
- Wrap: 24 b_fetch pulses in RUN, slot 1 → b_addr cycles 8..15 three times and ends at 8.
- Overflow: 9 res_push_i pulses → 9th push has res_we_o=0; err_o=1 and stays 1 after ack.
- Timeout: TIMEOUT=64, done_i never asserted → ack_o pulses 65 cycles after start and err_o=1.
- Reset mid-RUN at res_cnt=4 → all outputs 0 asynchronously, no ack. After release, the pending req_i is regranted starting from rr_ptr=0.

Source files
------------

// File: rtl/fios_job_scheduler.sv
// Round-robin front end for one shared FIOS Montgomery multiplier: grants a requester,
// starts the multiplier and turns its fetch/push strobes into operand/result RAM addresses.
module fios_job_scheduler #(
  parameter int s       = 8,
  parameter int NREQ    = 4,
  parameter int SLOT_W  = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*SLOT_W-1:0]   req_slot_i,
  output logic [NREQ-1:0]          ack_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic                     mult_start_o,
  input  logic                     a_shift_i,
  input  logic                     b_fetch_i,
  input  logic                     p_fetch_i,
  input  logic                     res_push_i,
  input  logic                     done_i,
  output logic [ADDR_W-1:0]        a_addr_o,
  output logic [ADDR_W-1:0]        b_addr_o,
  output logic [ADDR_W-1:0]        p_addr_o,
  output logic [ADDR_W-1:0]        res_addr_o,
  output logic                     res_we_o
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WIDX_W = (s > 1) ? $clog2(s) : 1;
  localparam int CNT_W  = $clog2(s + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_RUN,
    ST_ACK
  } state_t;

  // state_q is the observable FSM state for external checkers.
  state_t state_q, state_d;

  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  grant_idx_q;
  logic [SLOT_W-1:0] slot_q;
  logic [WIDX_W-1:0] a_idx_q, b_idx_q, p_idx_q;
  logic [CNT_W-1:0]  res_cnt_q;
  logic [WD_W-1:0]   wd_q;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic [SLOT_W-1:0] pick_slot;
  logic [IDX_W-1:0]  rr_next;
  logic [ADDR_W-1:0] base;
  logic [WIDX_W-1:0] a_nxt, b_nxt, p_nxt;
  logic              res_acc;
  logic [CNT_W-1:0]  res_cnt_eff;
  logic              wd_expire;

  // Requester handshake: req_i[k] is a level held until ack_o[k] pulses for one cycle;
  // the slot is sampled only in the IDLE cycle that grants k.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NREQ);
      if (req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_slot = req_slot_i[int'(pick_idx)*SLOT_W +: SLOT_W];
  assign rr_next   = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign base      = ADDR_W'(slot_q) * ADDR_W'(s);

  assign a_nxt = (a_idx_q == WIDX_W'(s - 1)) ? a_idx_q : a_idx_q + WIDX_W'(1);
  assign b_nxt = (b_idx_q == WIDX_W'(s - 1)) ? '0 : b_idx_q + WIDX_W'(1);
  assign p_nxt = (p_idx_q == WIDX_W'(s - 1)) ? '0 : p_idx_q + WIDX_W'(1);

  // A push is accepted only while the result slot still has room.
  assign res_acc     = (state_q == ST_RUN) && res_push_i && (res_cnt_q < CNT_W'(s));
  assign res_cnt_eff = res_cnt_q + CNT_W'(res_acc);
  assign wd_expire   = (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mult_start_o = 1'b0;
    busy_o       = 1'b1;
    ack_o        = '0;
    res_we_o     = res_acc;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (pick_valid) state_d = ST_GRANT;
      end
      ST_GRANT: state_d = ST_START;
      ST_START: begin
        mult_start_o = 1'b1;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (done_i || wd_expire) state_d = ST_ACK;
      end
      ST_ACK: begin
        ack_o   = NREQ'(1) << grant_idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      slot_q      <= '0;
      a_idx_q     <= '0;
      b_idx_q     <= '0;
      p_idx_q     <= '0;
      res_cnt_q   <= '0;
      wd_q        <= '0;
      err_o       <= 1'b0;
      a_addr_o    <= '0;
      b_addr_o    <= '0;
      p_addr_o    <= '0;
      res_addr_o  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_idx_q <= pick_idx;
            slot_q      <= pick_slot;
            rr_ptr_q    <= rr_next;
          end
        end
        ST_GRANT: begin
          a_idx_q    <= '0;
          b_idx_q    <= '0;
          p_idx_q    <= '0;
          res_cnt_q  <= '0;
          a_addr_o   <= base;
          b_addr_o   <= base;
          p_addr_o   <= base;
          res_addr_o <= base;
        end
        ST_START: wd_q <= '0;
        ST_RUN: begin
          wd_q <= wd_q + WD_W'(1);
          if (a_shift_i) begin
            a_idx_q  <= a_nxt;
            a_addr_o <= base + ADDR_W'(a_nxt);
          end
          if (b_fetch_i) begin
            b_idx_q  <= b_nxt;
            b_addr_o <= base + ADDR_W'(b_nxt);
          end
          if (p_fetch_i) begin
            p_idx_q  <= p_nxt;
            p_addr_o <= base + ADDR_W'(p_nxt);
          end
          // res_addr_o already points at the word being written; advance it afterwards.
          if (res_acc) begin
            res_cnt_q <= res_cnt_eff;
            if (res_cnt_eff < CNT_W'(s)) res_addr_o <= base + ADDR_W'(res_cnt_eff);
          end
          if (res_push_i && !res_acc) err_o <= 1'b1;
          if (done_i) begin
            if (res_cnt_eff != CNT_W'(s)) err_o <= 1'b1;
          end else if (wd_expire) begin
            err_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fios_job_scheduler.sv
// Directed bench for fios_job_scheduler: arbitration order, address generation,
// result-count and timeout errors, and reset behaviour.
module tb_fios_job_scheduler;
  localparam int S = 8, NREQ = 4, SLOT_W = 4, ADDR_W = 8, TIMEOUT = 64;

  logic                   clock_i = 1'b0;
  logic                   reset_i = 1'b1;
  logic [NREQ-1:0]        req_i = '0;
  logic [NREQ*SLOT_W-1:0] req_slot_i = '0;
  logic [NREQ-1:0]        ack_o;
  logic                   err_o, busy_o, mult_start_o;
  logic                   a_shift_i = 0, b_fetch_i = 0, p_fetch_i = 0, res_push_i = 0, done_i = 0;
  logic [ADDR_W-1:0]      a_addr_o, b_addr_o, p_addr_o, res_addr_o;
  logic                   res_we_o;

  int errors = 0;
  int checks = 0;

  fios_job_scheduler #(.s(S), .NREQ(NREQ), .SLOT_W(SLOT_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i), .req_slot_i(req_slot_i),
    .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o), .mult_start_o(mult_start_o),
    .a_shift_i(a_shift_i), .b_fetch_i(b_fetch_i), .p_fetch_i(p_fetch_i),
    .res_push_i(res_push_i), .done_i(done_i),
    .a_addr_o(a_addr_o), .b_addr_o(b_addr_o), .p_addr_o(p_addr_o),
    .res_addr_o(res_addr_o), .res_we_o(res_we_o)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // driver tasks
  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_strobes();
    a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0; res_push_i = 0; done_i = 0;
  endtask

  task automatic do_reset();
    clear_strobes();
    req_i = '0;
    req_slot_i = '0;
    reset_i = 1'b1;
    cyc();
    cyc();
    reset_i = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      res_push_i = 1'b1;
      cyc();
    end
    res_push_i = 1'b0;
  endtask

  // Eight pushes then done; returns with the DUT in its ack cycle.
  task automatic finish_job();
    push_n(S);
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    clear_strobes();
    reset_i = 1'b1;
    cyc();
    checks++; if (ack_o !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (mult_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", mult_start_o); end
    checks++; if ({a_addr_o, b_addr_o, p_addr_o, res_addr_o} !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", {a_addr_o, b_addr_o, p_addr_o, res_addr_o}); end
    checks++; if (res_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", res_we_o); end
    reset_i = 1'b0;
    cyc();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_single_job();
    do_reset();
    req_i = 4'b0001;
    req_slot_i = 16'h0003;
    cyc();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_grant_busy: got %b expected 1", busy_o); end
    checks++; if (mult_start_o !== 1'b0) begin errors++; $display("FAIL single_grant_start: got %b expected 0", mult_start_o); end
    req_slot_i = 16'h000f;
    cyc();
    checks++; if (mult_start_o !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", mult_start_o); end
    checks++; if (a_addr_o !== 8'd24) begin errors++; $display("FAIL single_a_base: got %0d expected 24", a_addr_o); end
    checks++; if (b_addr_o !== 8'd24) begin errors++; $display("FAIL single_b_base: got %0d expected 24", b_addr_o); end
    checks++; if (p_addr_o !== 8'd24) begin errors++; $display("FAIL single_p_base: got %0d expected 24", p_addr_o); end
    checks++; if (res_addr_o !== 8'd24) begin errors++; $display("FAIL single_res_base: got %0d expected 24", res_addr_o); end
    req_i = 4'b0000;
    cyc();
    checks++; if (mult_start_o !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b expected 0", mult_start_o); end
    for (int k = 0; k < S; k++) begin
      res_push_i = 1'b1;
      a_shift_i = 1'b1;
      p_fetch_i = (k < 3);
      #1;
      checks++; if (res_we_o !== 1'b1) begin errors++; $display("FAIL single_we[%0d]: got %b expected 1", k, res_we_o); end
      checks++; if (res_addr_o !== 8'(24 + k)) begin errors++; $display("FAIL single_res_addr[%0d]: got %0d expected %0d", k, res_addr_o, 24 + k); end
      cyc();
    end
    clear_strobes();
    checks++; if (a_addr_o !== 8'd31) begin errors++; $display("FAIL single_a_sat: got %0d expected 31", a_addr_o); end
    checks++; if (p_addr_o !== 8'd27) begin errors++; $display("FAIL single_p_addr: got %0d expected 27", p_addr_o); end
    checks++; if (b_addr_o !== 8'd24) begin errors++; $display("FAIL single_b_idle: got %0d expected 24", b_addr_o); end
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
    checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b expected 0001", ack_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err_o); end
    cyc();
    checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse: got %b expected 0000", ack_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy_o); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int n;
    do_reset();
    req_slot_i = {4'd5, 4'd4, 4'd3, 4'd2};
    req_i = 4'b1111;
    n = 0;
    for (int j = 0; j < 5; j++) begin
      while (mult_start_o !== 1'b1 && n < 8) begin
        cyc();
        n++;
      end
      checks++; if (n !== ((j == 0) ? 2 : 3)) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected %0d", j, n, (j == 0) ? 2 : 3); end
      checks++; if (a_addr_o !== 8'((order[j] + 2) * 8)) begin errors++; $display("FAIL rr_base[%0d]: got %0d expected %0d", j, a_addr_o, (order[j] + 2) * 8); end
      if (j == 4) req_i = 4'b0000;
      cyc();
      finish_job();
      checks++; if (ack_o !== 4'(1 << order[j])) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", j, ack_o, 4'(1 << order[j])); end
      cyc();
      n = 1;
      checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL rr_ack_pulse[%0d]: got %b expected 0000", j, ack_o); end
    end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rr_err: got %b expected 0", err_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    req_i = 4'b0001;
    req_slot_i = 16'h0001;
    cyc();
    cyc();
    req_i = 4'b0000;
    cyc();
    for (int i = 0; i < 24; i++) begin
      b_fetch_i = 1'b1;
      cyc();
      checks++; if (b_addr_o !== 8'(8 + ((i + 1) % 8))) begin errors++; $display("FAIL wrap_b[%0d]: got %0d expected %0d", i, b_addr_o, 8 + ((i + 1) % 8)); end
    end
    b_fetch_i = 1'b0;
    checks++; if (a_addr_o !== 8'd8) begin errors++; $display("FAIL wrap_a_untouched: got %0d expected 8", a_addr_o); end
    finish_job();
    checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL wrap_ack: got %b expected 0001", ack_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b expected 0", err_o); end
    cyc();
  endtask

  task automatic test_overflow();
    do_reset();
    req_i = 4'b0001;
    req_slot_i = 16'h0006;
    cyc();
    cyc();
    req_i = 4'b0000;
    cyc();
    for (int k = 0; k < 9; k++) begin
      res_push_i = 1'b1;
      #1;
      checks++; if (res_we_o !== (k < 8)) begin errors++; $display("FAIL ovf_we[%0d]: got %b expected %b", k, res_we_o, (k < 8)); end
      cyc();
      checks++; if (err_o !== (k == 8)) begin errors++; $display("FAIL ovf_err[%0d]: got %b expected %b", k, err_o, (k == 8)); end
    end
    res_push_i = 1'b0;
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
    checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL ovf_ack: got %b expected 0001", ack_o); end
    cyc();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %b expected 1", err_o); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req_i = 4'b0001;
    req_slot_i = 16'h0002;
    cyc();
    cyc();
    req_i = 4'b0000;
    n = 0;
    while (ack_o === 4'b0000 && n < 100) begin
      cyc();
      n++;
    end
    checks++; if (n !== 65) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected 65", n); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", err_o); end
    cyc();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_ignored_strobes();
    do_reset();
    a_shift_i = 1; b_fetch_i = 1; p_fetch_i = 1; res_push_i = 1; done_i = 1;
    #1;
    checks++; if (res_we_o !== 1'b0) begin errors++; $display("FAIL idle_we: got %b expected 0", res_we_o); end
    cyc();
    cyc();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL idle_err: got %b expected 0", err_o); end
    checks++; if ({a_addr_o, b_addr_o, p_addr_o, res_addr_o} !== 32'h0) begin errors++; $display("FAIL idle_addr: got %h expected 00000000", {a_addr_o, b_addr_o, p_addr_o, res_addr_o}); end
    checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL idle_ack: got %b expected 0000", ack_o); end
    req_i = 4'b0001;
    req_slot_i = 16'h0004;
    cyc();
    checks++; if (res_we_o !== 1'b0) begin errors++; $display("FAIL grant_we: got %b expected 0", res_we_o); end
    cyc();
    checks++; if (res_we_o !== 1'b0) begin errors++; $display("FAIL start_we: got %b expected 0", res_we_o); end
    checks++; if (mult_start_o !== 1'b1) begin errors++; $display("FAIL strobe_start: got %b expected 1", mult_start_o); end
    clear_strobes();
    req_i = 4'b0000;
    cyc();
    checks++; if (a_addr_o !== 8'd32) begin errors++; $display("FAIL strobe_a_addr: got %0d expected 32", a_addr_o); end
    checks++; if (res_addr_o !== 8'd32) begin errors++; $display("FAIL strobe_res_addr: got %0d expected 32", res_addr_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL strobe_busy: got %b expected 1", busy_o); end
    finish_job();
    checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL strobe_ack: got %b expected 0001", ack_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL strobe_err: got %b expected 0", err_o); end
    cyc();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req_i = 4'b0011;
    req_slot_i = 16'h0075;
    cyc();
    cyc();
    checks++; if (a_addr_o !== 8'd40) begin errors++; $display("FAIL midrst_first_base: got %0d expected 40", a_addr_o); end
    cyc();
    push_n(4);
    checks++; if (res_addr_o !== 8'd44) begin errors++; $display("FAIL midrst_res_addr: got %0d expected 44", res_addr_o); end
    #2;
    res_push_i = 1'b1;
    reset_i = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    checks++; if (res_we_o !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b expected 0", res_we_o); end
    checks++; if ({a_addr_o, res_addr_o} !== 16'h0) begin errors++; $display("FAIL midrst_addr: got %h expected 0000", {a_addr_o, res_addr_o}); end
    checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL midrst_ack: got %b expected 0000", ack_o); end
    res_push_i = 1'b0;
    cyc();
    checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL midrst_no_ack: got %b expected 0000", ack_o); end
    reset_i = 1'b0;
    cyc();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midrst_regrant: got %b expected 1", busy_o); end
    cyc();
    checks++; if (a_addr_o !== 8'd40) begin errors++; $display("FAIL midrst_rr_ptr: got %0d expected 40", a_addr_o); end
    req_i = 4'b0000;
    cyc();
    finish_job();
    checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL midrst_ack_after: got %b expected 0001", ack_o); end
    cyc();
  endtask

  // run + report
  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_wrap();
    test_overflow();
    test_timeout();
    test_ignored_strobes();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
